// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Contents: opcode constants, ALU operation codes, PC source select,
// sequencer state encoding and branch-condition helpers.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_e;

  // funct3 010/011 are unassigned in the branch space.
  function automatic logic branch_f3_valid(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       lt,
                                        input logic       ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode.
// Ports:
//   opcode_i, funct3_i, funct7_i : latched instruction fields
//   alu_op_o                     : ALU operation (rv_ctrl_pkg::alu_op_e)
//   alu_src_o                    : 0 = rs2, 1 = immediate
module alu_op_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    alu_op_o,
  output logic       alu_src_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        case ({funct7_i, funct3_i})
          10'b0000000_000: alu_op_o = ALU_ADD;
          10'b0100000_000: alu_op_o = ALU_SUB;
          10'b0000000_001: alu_op_o = ALU_SLL;
          10'b0000000_010: alu_op_o = ALU_SLT;
          10'b0000000_011: alu_op_o = ALU_SLTU;
          10'b0000000_100: alu_op_o = ALU_XOR;
          10'b0000000_101: alu_op_o = ALU_SRL;
          10'b0100000_101: alu_op_o = ALU_SRA;
          10'b0000000_110: alu_op_o = ALU_OR;
          10'b0000000_111: alu_op_o = ALU_AND;
          default:         alu_op_o = ALU_ADD;
        endcase
      end
      OPC_ITYPE: begin
        alu_src_o = 1'b1;
        case (funct3_i)
          3'b000:  alu_op_o = ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      OPC_BRANCH: alu_op_o = ALU_SUB;
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: begin
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b1;
      end
      default: begin
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control FSM: FETCH, DECODE, EXEC, MEM, WB.
// Ports:
//   clk, rst (sync, active-high), run : start control, sampled in IDLE
//   opcode, funct3, funct7            : instruction fields (stable from DECODE)
//   alu_zero, alu_lt, alu_ltu         : ALU compare flags
//   imem_ready, dmem_ready            : memory handshakes
//   imem_req, ir_we                   : fetch request / IR latch
//   dmem_req, dmem_we                 : data access request / store qualifier
//   alu_src, alu_op                   : ALU operand and operation selects
//   reg_we, mem_to_reg, link          : register writeback controls
//   pc_we, pc_sel                     : PC update controls
//   halted, illegal                   : HALT/TRAP status
//   retired                           : completed-instruction count (wraps)
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             link,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  alu_op_e            dec_alu_op;
  logic               dec_alu_src;

  alu_op_decode u_alu_op_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src)
  );

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    halted     = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE,
          OPC_BRANCH, OPC_JAL, OPC_JALR: state_d = S_EXEC;
          OPC_SYSTEM:                    state_d = S_HALT;
          default:                       state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        alu_src = dec_alu_src;
        alu_op  = dec_alu_op;
        case (opcode)
          OPC_BRANCH: begin
            if (branch_f3_valid(funct3)) begin
              pc_we   = 1'b1;
              pc_sel  = branch_taken(funct3, alu_zero, alu_lt, alu_ltu) ? PC_IMM : PC_PLUS4;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_TRAP;
            end
          end
          OPC_LOAD, OPC_STORE:                      state_d = S_MEM;
          OPC_RTYPE, OPC_ITYPE, OPC_JAL, OPC_JALR:  state_d = S_WB;
          default:                                  state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        // ALU selects stay applied so the computed address is steady for the whole access.
        alu_src  = dec_alu_src;
        alu_op   = dec_alu_op;
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        alu_src    = dec_alu_src;
        alu_op     = dec_alu_op;
        reg_we     = 1'b1;
        mem_to_reg = (opcode == OPC_LOAD);
        link       = (opcode == OPC_JAL) || (opcode == OPC_JALR);
        pc_we      = 1'b1;
        if (opcode == OPC_JALR)     pc_sel = PC_JALR;
        else if (opcode == OPC_JAL) pc_sel = PC_IMM;
        else                        pc_sel = PC_PLUS4;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_TRAP: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
